sap_fetch_unit: RTL and testbench

Instruction-fetch stage of the SAP-1 CPU, directly upstream of the controller. Holds the program counter (PC), memory address register (MAR), 16×8 program/data RAM and instruction register (IR). All register loads and W-bus drives are decoded from the controller's 12-bit control word. Supplies the controller its 4-bit `instruction` opcode, plus a RAM programming port used while the CPU is held.

---
 rtl/sap_pkg.sv | 32 +++
 rtl/sap_fetch_unit_if.sv | 35 +++
 rtl/sap_ram16x8.sv | 24 ++
 rtl/sap_fetch_unit.sv | 75 +++++++
 tb/tb_sap_fetch_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: the control-word bit positions, opcodes, the
// idle (NOP) control word and the control-word type. No ports.
package sap_pkg;

   localparam int CW_W = 12;

   // Control-word bit positions. A _N suffix marks an active-low bit.
   localparam int CP   = 11;
   localparam int EP   = 10;
   localparam int LM_N = 9;
   localparam int CE_N = 8;
   localparam int LI_N = 7;
   localparam int EI_N = 6;
   localparam int LA_N = 5;
   localparam int EA   = 4;
   localparam int SU   = 3;
   localparam int EU   = 2;
   localparam int LB_N = 1;
   localparam int LO_N = 0;

   localparam logic [3:0] OP_LDA  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_OUT  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef logic [CW_W-1:0] control_word_t;

   // Every enable inactive: no loads, no bus drivers.
   localparam control_word_t NOP_WORD = 12'b0011_1110_0011;

endpackage

// File: rtl/sap_fetch_unit_if.sv
// Fetch-unit signal bundle between the controller/W-bus side (master) and
// the fetch unit (slave).
//   control_word  controller -> fetch   12-bit decoded control word
//   bus_in        W-bus      -> fetch   resolved bus value
//   bus_out/bus_oe/bus_conflict         fetch unit's bus drive and status
//   instruction/halted                  opcode and sticky halt to controller
//   prog_en/prog_we/prog_addr/prog_data RAM programming port
interface sap_fetch_unit_if
   import sap_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   control_word_t     control_word;
   logic [DATA_W-1:0] bus_in;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic              bus_conflict;
   logic [3:0]        instruction;
   logic              halted;
   logic              prog_en;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;

   modport master (
      output control_word, bus_in, prog_en, prog_we, prog_addr, prog_data,
      input  bus_out, bus_oe, bus_conflict, instruction, halted
   );

   modport slave (
      input  control_word, bus_in, prog_en, prog_we, prog_addr, prog_data,
      output bus_out, bus_oe, bus_conflict, instruction, halted
   );
endinterface

// File: rtl/sap_ram16x8.sv
// Program/data RAM: one clocked write port, one asynchronous read port.
// Contents are not affected by reset.
//   clock        write clock
//   we/waddr/wdata  write port
//   raddr/rdata     combinational read port
module sap_ram16x8 #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sap_fetch_unit.sv
// SAP-1 instruction-fetch stage: PC, MAR, RAM, IR, halt flag and W-bus mux,
// all decoded from the controller's control word.
//   clock  system clock (posedge)
//   reset  synchronous, active-high
//   bus    sap_fetch_unit_if slave: control word, W-bus in/out, opcode,
//          halt status and RAM programming port
module sap_fetch_unit
   import sap_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   sap_fetch_unit_if.slave  bus
);
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic              halted_q;
   logic [DATA_W-1:0] ram_rdata;

   logic cpu_active;
   logic en_pc, en_ram, en_ir;
   logic unused_cw_bits;

   control_word_t cw;
   assign cw = bus.control_word;

   // Bits consumed by the accumulator/B/output stages, not here.
   assign unused_cw_bits = ^{cw[LA_N], cw[EA], cw[SU], cw[EU], cw[LB_N], cw[LO_N]};

   // Program mode and halt both mask the whole control word.
   assign cpu_active = !bus.prog_en && !halted_q;
   assign en_pc  = cpu_active && cw[EP];
   assign en_ram = cpu_active && !cw[CE_N];
   assign en_ir  = cpu_active && !cw[EI_N];

   sap_ram16x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clock (clock),
      .we    (bus.prog_en && bus.prog_we),
      .waddr (bus.prog_addr),
      .wdata (bus.prog_data),
      .raddr (mar),
      .rdata (ram_rdata)
   );

   always_comb begin
      bus.bus_out = '0;
      if (en_pc)       bus.bus_out = DATA_W'(pc);
      else if (en_ram) bus.bus_out = ram_rdata;
      else if (en_ir)  bus.bus_out = DATA_W'(ir[ADDR_W-1:0]);
   end

   assign bus.bus_oe       = en_pc || en_ram || en_ir;
   assign bus.bus_conflict = (en_pc && en_ram) || (en_pc && en_ir) || (en_ram && en_ir);
   assign bus.instruction  = ir[DATA_W-1 -: 4];
   assign bus.halted       = halted_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         pc       <= '0;
         mar      <= '0;
         ir       <= '0;
         halted_q <= 1'b0;
      end else if (cpu_active) begin
         if (cw[CP])    pc  <= pc + ADDR_W'(1);
         if (!cw[LM_N]) mar <= bus.bus_in[ADDR_W-1:0];
         if (!cw[LI_N]) begin
            ir <= bus.bus_in;
            if (bus.bus_in[DATA_W-1 -: 4] == OP_HALT) halted_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sap_fetch_unit.sv
module tb_sap_fetch_unit;
   import sap_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   sap_fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

   sap_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference state
   logic [7:0] mem_m [16];
   logic [3:0] pc_m, mar_m;
   logic [7:0] ir_m;
   logic       halted_m;

   function automatic control_word_t w_t1();
      control_word_t w = NOP_WORD; w[EP] = 1'b1; w[LM_N] = 1'b0; return w;
   endfunction
   function automatic control_word_t w_t2();
      control_word_t w = NOP_WORD; w[CP] = 1'b1; return w;
   endfunction
   function automatic control_word_t w_t3();
      control_word_t w = NOP_WORD; w[CE_N] = 1'b0; w[LI_N] = 1'b0; return w;
   endfunction
   function automatic control_word_t w_t4();
      control_word_t w = NOP_WORD; w[EI_N] = 1'b0; w[LM_N] = 1'b0; return w;
   endfunction
   function automatic control_word_t w_t5();
      control_word_t w = NOP_WORD; w[CE_N] = 1'b0; w[LA_N] = 1'b0; return w;
   endfunction
   function automatic control_word_t w_lm();
      control_word_t w = NOP_WORD; w[LM_N] = 1'b0; return w;
   endfunction

   // Expected bus behaviour from the current model state and inputs.
   task automatic exp_bus(output logic [7:0] o, output logic oe, output logic cf);
      int n;
      bit p, r, i;
      bit act;
      act = !bus_if.prog_en && !halted_m;
      p = act && bus_if.control_word[EP];
      r = act && !bus_if.control_word[CE_N];
      i = act && !bus_if.control_word[EI_N];
      n = int'(p) + int'(r) + int'(i);
      oe = (n > 0);
      cf = (n > 1);
      if (p)      o = {4'h0, pc_m};
      else if (r) o = mem_m[mar_m];
      else if (i) o = {4'h0, ir_m[3:0]};
      else        o = 8'h00;
   endtask

   task automatic model_edge();
      control_word_t w;
      w = bus_if.control_word;
      if (bus_if.prog_en && bus_if.prog_we) mem_m[bus_if.prog_addr] = bus_if.prog_data;
      if (reset) begin
         pc_m = 0; mar_m = 0; ir_m = 0; halted_m = 0;
      end else if (!bus_if.prog_en && !halted_m) begin
         if (w[CP])    pc_m  = (pc_m + 4'd1) % 16;
         if (!w[LM_N]) mar_m = bus_if.bus_in[3:0];
         if (!w[LI_N]) begin
            ir_m = bus_if.bus_in;
            if (bus_if.bus_in[7:4] == 4'hF) halted_m = 1;
         end
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic cpu(input control_word_t w, input bit loop);
      bus_if.control_word = w;
      #1;
      if (loop) bus_if.bus_in = bus_if.bus_out;
      cycle();
   endtask

   task automatic program_word(input logic [3:0] a, input logic [7:0] d);
      bus_if.prog_en = 1; bus_if.prog_we = 1;
      bus_if.prog_addr = a; bus_if.prog_data = d;
      cycle();
      bus_if.prog_we = 0; bus_if.prog_en = 0;
   endtask

   task automatic test_reset();
      reset = 1; bus_if.control_word = NOP_WORD;
      cycle(); cycle();
      reset = 0;
      repeat (3) cycle();
      checks++; if (dut.pc !== 4'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", dut.pc); end
      checks++; if (dut.mar !== 4'h0) begin errors++; $display("FAIL reset_mar got=%h want=0", dut.mar); end
      checks++; if (dut.ir !== 8'h00) begin errors++; $display("FAIL reset_ir got=%h want=00", dut.ir); end
      checks++; if (bus_if.bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b want=0", bus_if.bus_oe); end
      checks++; if (bus_if.bus_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got=%b want=0", bus_if.bus_conflict); end
      checks++; if (bus_if.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", bus_if.halted); end
   endtask

   task automatic test_fetch();
      program_word(4'h0, 8'h09);
      program_word(4'h9, 8'h2A);
      cpu(w_t1(), 1);
      checks++; if (dut.mar !== 4'h0) begin errors++; $display("FAIL fetch_t1_mar got=%h want=0", dut.mar); end
      cpu(w_t2(), 1);
      checks++; if (dut.pc !== 4'h1) begin errors++; $display("FAIL fetch_t2_pc got=%h want=1", dut.pc); end
      cpu(w_t3(), 1);
      checks++; if (dut.ir !== 8'h09) begin errors++; $display("FAIL fetch_t3_ir got=%h want=09", dut.ir); end
      checks++; if (bus_if.instruction !== OP_LDA) begin errors++; $display("FAIL fetch_opcode got=%h want=0", bus_if.instruction); end
      cpu(w_t4(), 1);
      checks++; if (dut.mar !== 4'h9) begin errors++; $display("FAIL fetch_t4_mar got=%h want=9", dut.mar); end
      bus_if.control_word = w_t5();
      #1;
      checks++; if (bus_if.bus_out !== 8'h2A) begin errors++; $display("FAIL fetch_t5_bus got=%h want=2a", bus_if.bus_out); end
      checks++; if (bus_if.bus_oe !== 1'b1) begin errors++; $display("FAIL fetch_t5_oe got=%b want=1", bus_if.bus_oe); end
      bus_if.control_word = NOP_WORD;
      #1;
   endtask

   task automatic test_pc_wrap();
      // PC is 1 after the fetch test
      repeat (14) cpu(w_t2(), 0);
      checks++; if (dut.pc !== 4'hF) begin errors++; $display("FAIL wrap_pc15 got=%h want=f", dut.pc); end
      cpu(w_t2(), 0);
      checks++; if (dut.pc !== 4'h0) begin errors++; $display("FAIL wrap_pc0 got=%h want=0", dut.pc); end
      checks++; if (dut.mar !== 4'h9 || dut.ir !== 8'h09) begin errors++; $display("FAIL wrap_side got mar=%h ir=%h want 9/09", dut.mar, dut.ir); end
   endtask

   task automatic test_halt();
      reset = 1; cpu(NOP_WORD, 0); reset = 0;
      program_word(4'h3, 8'hF0);
      repeat (3) cpu(w_t2(), 0);
      cpu(w_t1(), 1);
      cpu(w_t2(), 1);
      cpu(w_t3(), 1);
      checks++; if (dut.ir !== 8'hF0) begin errors++; $display("FAIL halt_ir got=%h want=f0", dut.ir); end
      checks++; if (bus_if.halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b want=1", bus_if.halted); end
      bus_if.control_word = w_t1();
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) begin errors++; $display("FAIL halt_oe got=%b want=0", bus_if.bus_oe); end
      bus_if.bus_in = 8'h0C;
      cycle();
      cpu(w_t2(), 0);
      checks++; if (dut.pc !== 4'h4 || dut.mar !== 4'h3) begin errors++; $display("FAIL halt_frozen got pc=%h mar=%h want 4/3", dut.pc, dut.mar); end
      checks++; if (bus_if.instruction !== OP_HALT) begin errors++; $display("FAIL halt_opcode got=%h want=f", bus_if.instruction); end
      reset = 1; cpu(NOP_WORD, 0); reset = 0;
      checks++; if (bus_if.halted !== 1'b0 || dut.pc !== 4'h0) begin errors++; $display("FAIL halt_clear got halted=%b pc=%h want 0/0", bus_if.halted, dut.pc); end
   endtask

   task automatic test_conflict();
      control_word_t w;
      repeat (5) cpu(w_t2(), 0);
      w = NOP_WORD; w[EP] = 1'b1; w[CE_N] = 1'b0;
      bus_if.control_word = w;
      #1;
      checks++; if (bus_if.bus_out !== 8'h05) begin errors++; $display("FAIL conflict_bus got=%h want=05", bus_if.bus_out); end
      checks++; if (bus_if.bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_flag got=%b want=1", bus_if.bus_conflict); end
      checks++; if (bus_if.bus_oe !== 1'b1) begin errors++; $display("FAIL conflict_oe got=%b want=1", bus_if.bus_oe); end
      bus_if.control_word = NOP_WORD;
      #1;
   endtask

   task automatic test_reset_priority();
      control_word_t w;
      bus_if.bus_in = 8'h77;
      reset = 1; cpu(w_t3(), 0); reset = 0;
      checks++; if (dut.ir !== 8'h00) begin errors++; $display("FAIL rst_t3_ir got=%h want=00", dut.ir); end
      bus_if.bus_in = 8'h05; cpu(w_lm(), 0);
      bus_if.prog_en = 1;
      w = w_t1(); w[CE_N] = 1'b0;
      bus_if.control_word = w;
      bus_if.bus_in = 8'h0B;
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0 || bus_if.bus_conflict !== 1'b0) begin errors++; $display("FAIL prog_bus got oe=%b cf=%b want 0/0", bus_if.bus_oe, bus_if.bus_conflict); end
      cycle();
      checks++; if (dut.mar !== 4'h5) begin errors++; $display("FAIL prog_mar got=%h want=5", dut.mar); end
      // RAM write coincident with reset still lands
      bus_if.prog_we = 1; bus_if.prog_addr = 4'h6; bus_if.prog_data = 8'h5A;
      reset = 1; cycle(); reset = 0;
      bus_if.prog_we = 0; bus_if.prog_en = 0;
      bus_if.bus_in = 8'h06; cpu(w_lm(), 0);
      w = NOP_WORD; w[CE_N] = 1'b0;
      bus_if.control_word = w;
      #1;
      checks++; if (bus_if.bus_out !== 8'h5A) begin errors++; $display("FAIL rst_prog_write got=%h want=5a", bus_if.bus_out); end
      bus_if.control_word = NOP_WORD;
      #1;
   endtask

   task automatic test_random();
      logic [7:0] eo;
      logic eoe, ecf;
      for (int a = 0; a < 16; a++) program_word(4'(a), 8'($urandom));
      reset = 1; cycle(); reset = 0;
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 24) == 0);
         bus_if.prog_en = ($urandom_range(0, 7) == 0);
         bus_if.prog_we = $urandom_range(0, 1) == 1;
         bus_if.prog_addr = 4'($urandom);
         bus_if.prog_data = 8'($urandom);
         bus_if.control_word = control_word_t'($urandom);
         bus_if.bus_in = 8'($urandom);
         #1;
         if (bus_if.bus_oe && $urandom_range(0, 1) == 1) bus_if.bus_in = bus_if.bus_out;
         if (!reset) begin
            exp_bus(eo, eoe, ecf);
            checks++;
            if (bus_if.bus_out !== eo || bus_if.bus_oe !== eoe || bus_if.bus_conflict !== ecf) begin
               errors++;
               $display("FAIL rnd_bus n=%0d got out=%h oe=%b cf=%b want out=%h oe=%b cf=%b", n, bus_if.bus_out, bus_if.bus_oe, bus_if.bus_conflict, eo, eoe, ecf);
            end
         end
         cycle();
         checks++;
         if (dut.pc !== pc_m || dut.mar !== mar_m || dut.ir !== ir_m || bus_if.halted !== halted_m || bus_if.instruction !== ir_m[7:4]) begin
            errors++;
            $display("FAIL rnd_regs n=%0d got pc=%h mar=%h ir=%h h=%b want pc=%h mar=%h ir=%h h=%b", n, dut.pc, dut.mar, dut.ir, bus_if.halted, pc_m, mar_m, ir_m, halted_m);
         end
      end
      reset = 0; bus_if.prog_en = 0; bus_if.prog_we = 0;
   endtask

   initial begin
      reset = 1;
      bus_if.control_word = NOP_WORD;
      bus_if.bus_in = 8'h00;
      bus_if.prog_en = 0;
      bus_if.prog_we = 0;
      bus_if.prog_addr = 4'h0;
      bus_if.prog_data = 8'h00;
      pc_m = 0; mar_m = 0; ir_m = 0; halted_m = 0;
      for (int a = 0; a < 16; a++) mem_m[a] = 8'h00;
      test_reset();
      test_fetch();
      test_pc_wrap();
      test_halt();
      test_conflict();
      test_reset_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
